// File: rtl/bp_pkg.sv
// Shared constants and saturating arithmetic helpers for the branch predictor.
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;
    localparam int BP_CTR_INIT     = 1;
    localparam int BP_SAT_MAX_W    = 64;

    // Width-generic helpers: operands live in 64 bits, 'width' sets the saturation ceiling.
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        return (value >= sat_max(width)) ? sat_max(width) : value + 64'd1;
    endfunction

    function automatic logic [63:0] sat_dec(input logic [63:0] value, input int unsigned width);
        return (value == 64'd0) ? 64'd0 : value - 64'd1;
    endfunction

endpackage

// File: rtl/bp_perf_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module bp_perf_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= CNT_W'(sat_inc(64'(cnt_q), CNT_W));
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_table.sv
// Bimodal/gshare direction predictor: counter table, speculative GHR with
// mispredict recovery, and branch/mispredict performance counters.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CTR_INIT = BP_CTR_INIT,
    parameter int MODE     = BP_MODE_BIMODAL,
    parameter int GHR_BITS = 4,
    parameter int CNT_W    = 32,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lookup_valid_i,
    input  logic [PC_W-1:0]     lookup_pc_i,
    output logic                predict_o,
    output logic [IDX_W-1:0]    lookup_idx_o,
    output logic [GHR_BITS-1:0] lookup_ghr_o,
    input  logic                update_valid_i,
    input  logic [IDX_W-1:0]    update_idx_i,
    input  logic [GHR_BITS-1:0] update_ghr_i,
    input  logic                update_taken_i,
    input  logic                update_mispredict_i,
    input  logic                clear_cnt_i,
    output logic [CNT_W-1:0]    branch_cnt_o,
    output logic [CNT_W-1:0]    mispredict_cnt_o
);

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_chk_entries
        $error("branch_predictor_table: ENTRIES must be a power of 2 and at least 2");
    end
    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_chk_ctr_bits
        $error("branch_predictor_table: CTR_BITS must be within 1..4");
    end
    if (CTR_INIT < 0 || CTR_INIT >= (1 << CTR_BITS)) begin : g_chk_ctr_init
        $error("branch_predictor_table: CTR_INIT does not fit in CTR_BITS");
    end
    if (MODE != BP_MODE_BIMODAL && MODE != BP_MODE_GSHARE) begin : g_chk_mode
        $error("branch_predictor_table: MODE must be 0 (bimodal) or 1 (gshare)");
    end
    if (GHR_BITS < 1 || (MODE == BP_MODE_GSHARE && GHR_BITS > IDX_W)) begin : g_chk_ghr
        $error("branch_predictor_table: GHR_BITS must be >= 1 and <= IDX_W in gshare mode");
    end
    if (PC_W < IDX_W + 2) begin : g_chk_pc
        $error("branch_predictor_table: PC_W too narrow for the table index");
    end
    if (CNT_W < 1 || CNT_W > BP_SAT_MAX_W) begin : g_chk_cnt
        $error("branch_predictor_table: CNT_W must be within 1..64");
    end

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;
    logic [IDX_W-1:0]    base_idx;
    logic [IDX_W-1:0]    idx;
    logic [GHR_BITS:0]   ghr_recover_cat;
    logic [GHR_BITS:0]   ghr_lookup_cat;

    // Instruction PCs are word aligned, so the two LSBs carry no information.
    assign base_idx = lookup_pc_i[IDX_W+1:2];

    if (MODE == BP_MODE_GSHARE) begin : g_gshare
        assign idx = base_idx ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
        assign idx = base_idx;
    end

    assign predict_o    = ctr_q[idx][CTR_BITS-1];
    assign lookup_idx_o = idx;
    assign lookup_ghr_o = ghr_q;

    assign ghr_recover_cat = {update_ghr_i, update_taken_i};
    assign ghr_lookup_cat  = {ghr_q, predict_o};

    // A resolved mispredict rebuilds history from the snapshot; any lookup in
    // the same cycle is on the wrong path and must not be shifted in.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid_i && update_mispredict_i) begin
            ghr_d = ghr_recover_cat[GHR_BITS-1:0];
        end else if (lookup_valid_i) begin
            ghr_d = ghr_lookup_cat[GHR_BITS-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_BITS'(CTR_INIT);
            end
        end else if (update_valid_i) begin
            if (update_taken_i) begin
                ctr_q[update_idx_i] <= CTR_BITS'(sat_inc(64'(ctr_q[update_idx_i]), CTR_BITS));
            end else begin
                ctr_q[update_idx_i] <= CTR_BITS'(sat_dec(64'(ctr_q[update_idx_i]), CTR_BITS));
            end
        end
    end

    bp_perf_counter #(
        .CNT_W (CNT_W)
    ) u_branch_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (update_valid_i),
        .clr_i (clear_cnt_i),
        .cnt_o (branch_cnt_o)
    );

    bp_perf_counter #(
        .CNT_W (CNT_W)
    ) u_mispredict_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (update_valid_i & update_mispredict_i),
        .clr_i (clear_cnt_i),
        .cnt_o (mispredict_cnt_o)
    );

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench: a bimodal instance (4-bit perf counters) and a gshare instance
// driven from hand-computed vectors.
module tb_branch_predictor_table;

    logic clk = 1'b0;
    logic rst_n;

    logic        bim_lookup_valid;
    logic [31:0] bim_lookup_pc;
    logic        bim_predict;
    logic [3:0]  bim_lookup_idx;
    logic [3:0]  bim_lookup_ghr;
    logic        bim_update_valid;
    logic [3:0]  bim_update_idx;
    logic [3:0]  bim_update_ghr;
    logic        bim_update_taken;
    logic        bim_update_mispredict;
    logic        bim_clear_cnt;
    logic [3:0]  bim_branch_cnt;
    logic [3:0]  bim_mispredict_cnt;

    logic        gsh_lookup_valid;
    logic [31:0] gsh_lookup_pc;
    logic        gsh_predict;
    logic [3:0]  gsh_lookup_idx;
    logic [3:0]  gsh_lookup_ghr;
    logic        gsh_update_valid;
    logic [3:0]  gsh_update_idx;
    logic [3:0]  gsh_update_ghr;
    logic        gsh_update_taken;
    logic        gsh_update_mispredict;
    logic        gsh_clear_cnt;
    logic [31:0] gsh_branch_cnt;
    logic [31:0] gsh_mispredict_cnt;

    int num_checks = 0;
    int num_fails  = 0;

    always #20 clk = ~clk;

    branch_predictor_table #(
        .PC_W(32), .ENTRIES(16), .CTR_BITS(2), .CTR_INIT(1),
        .MODE(0), .GHR_BITS(4), .CNT_W(4)
    ) u_bim (
        .clk_i               (clk),
        .rst_i               (rst_n),
        .lookup_valid_i      (bim_lookup_valid),
        .lookup_pc_i         (bim_lookup_pc),
        .predict_o           (bim_predict),
        .lookup_idx_o        (bim_lookup_idx),
        .lookup_ghr_o        (bim_lookup_ghr),
        .update_valid_i      (bim_update_valid),
        .update_idx_i        (bim_update_idx),
        .update_ghr_i        (bim_update_ghr),
        .update_taken_i      (bim_update_taken),
        .update_mispredict_i (bim_update_mispredict),
        .clear_cnt_i         (bim_clear_cnt),
        .branch_cnt_o        (bim_branch_cnt),
        .mispredict_cnt_o    (bim_mispredict_cnt)
    );

    branch_predictor_table #(
        .PC_W(32), .ENTRIES(16), .CTR_BITS(2), .CTR_INIT(1),
        .MODE(1), .GHR_BITS(4), .CNT_W(32)
    ) u_gsh (
        .clk_i               (clk),
        .rst_i               (rst_n),
        .lookup_valid_i      (gsh_lookup_valid),
        .lookup_pc_i         (gsh_lookup_pc),
        .predict_o           (gsh_predict),
        .lookup_idx_o        (gsh_lookup_idx),
        .lookup_ghr_o        (gsh_lookup_ghr),
        .update_valid_i      (gsh_update_valid),
        .update_idx_i        (gsh_update_idx),
        .update_ghr_i        (gsh_update_ghr),
        .update_taken_i      (gsh_update_taken),
        .update_mispredict_i (gsh_update_mispredict),
        .clear_cnt_i         (gsh_clear_cnt),
        .branch_cnt_o        (gsh_branch_cnt),
        .mispredict_cnt_o    (gsh_mispredict_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One bimodal cycle: inputs change at the falling edge, outputs are sampled 1 unit later.
    task automatic applyStimulus(input logic lv, input logic [31:0] pc, input logic uv,
                                 input logic [3:0] uidx, input logic taken,
                                 input logic mis, input logic clr);
        @(negedge clk);
        bim_lookup_valid      = lv;
        bim_lookup_pc         = pc;
        bim_update_valid      = uv;
        bim_update_idx        = uidx;
        bim_update_ghr        = 4'b0000;
        bim_update_taken      = taken;
        bim_update_mispredict = mis;
        bim_clear_cnt         = clr;
        #1;
    endtask

    task automatic applyGshareStimulus(input logic lv, input logic [31:0] pc, input logic uv,
                                       input logic [3:0] uidx, input logic [3:0] ughr,
                                       input logic taken, input logic mis);
        @(negedge clk);
        gsh_lookup_valid      = lv;
        gsh_lookup_pc         = pc;
        gsh_update_valid      = uv;
        gsh_update_idx        = uidx;
        gsh_update_ghr        = ughr;
        gsh_update_taken      = taken;
        gsh_update_mispredict = mis;
        gsh_clear_cnt         = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bim_lookup_valid = 1'b1; bim_lookup_pc = 32'h0C; bim_update_valid = 1'b0;
        bim_update_idx = '0; bim_update_ghr = '0; bim_update_taken = 1'b0;
        bim_update_mispredict = 1'b0; bim_clear_cnt = 1'b0;
        gsh_lookup_valid = 1'b0; gsh_lookup_pc = '0; gsh_update_valid = 1'b0;
        gsh_update_idx = '0; gsh_update_ghr = '0; gsh_update_taken = 1'b0;
        gsh_update_mispredict = 1'b0; gsh_clear_cnt = 1'b0;
        #5;
        checkOutput("rst_predict", 64'(bim_predict), 64'd0);
        checkOutput("rst_branch_cnt", 64'(bim_branch_cnt), 64'd0);
        checkOutput("rst_ghr", 64'(bim_lookup_ghr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bimodal training on idx 3
        applyStimulus(1'b0, 32'h00, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_taken1_predict", 64'(bim_predict), 64'd1);
        checkOutput("bim_taken1_idx", 64'(bim_lookup_idx), 64'd3);
        applyStimulus(1'b1, 32'h4C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_alias_idx", 64'(bim_lookup_idx), 64'd3);
        checkOutput("bim_alias_predict", 64'(bim_predict), 64'd1);
        applyStimulus(1'b1, 32'h08, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_neighbour_untouched", 64'(bim_predict), 64'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h00, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_sat_high_predict", 64'(bim_predict), 64'd1);
        applyStimulus(1'b0, 32'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_nt1_predict", 64'(bim_predict), 64'd1);
        applyStimulus(1'b0, 32'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_nt2_predict", 64'(bim_predict), 64'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_sat_low_predict", 64'(bim_predict), 64'd0);
        // From 0, one taken must reach 1 (still not-taken); a wrap would reach 3 or 2
        applyStimulus(1'b0, 32'h00, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("bim_ctr1_predict", 64'(bim_predict), 64'd0);

        // Same-cycle lookup and update of idx 3: no bypass
        applyStimulus(1'b1, 32'h0C, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("rw_same_cycle", 64'(bim_predict), 64'd0);
        applyStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rw_next_cycle", 64'(bim_predict), 64'd1);
        checkOutput("bim_branch_cnt", 64'(bim_branch_cnt), 64'd11);
        checkOutput("bim_mispredict_cnt", 64'(bim_mispredict_cnt), 64'd0);

        // Performance counters
        applyStimulus(1'b0, 32'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("perf_clear_branch", 64'(bim_branch_cnt), 64'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 32'h00, 1'b1, 4'd5, 1'b1, (i % 4) == 0, 1'b0);
        end
        applyStimulus(1'b0, 32'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("perf_branch_sat", 64'(bim_branch_cnt), 64'd15);
        checkOutput("perf_mispredict", 64'(bim_mispredict_cnt), 64'd5);
        applyStimulus(1'b0, 32'h00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("perf_clear_prio_branch", 64'(bim_branch_cnt), 64'd0);
        checkOutput("perf_clear_prio_mispredict", 64'(bim_mispredict_cnt), 64'd0);
        applyStimulus(1'b0, 32'h00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("perf_post_clear_branch", 64'(bim_branch_cnt), 64'd1);
        checkOutput("perf_post_clear_mispredict", 64'(bim_mispredict_cnt), 64'd1);

        // gshare indexing and GHR behaviour
        applyGshareStimulus(1'b0, 32'h00, 1'b1, 4'd1, 4'b0000, 1'b1, 1'b0);
        applyGshareStimulus(1'b1, 32'h04, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
        checkOutput("gsh_l1_ghr", 64'(gsh_lookup_ghr), 64'h0);
        checkOutput("gsh_l1_idx", 64'(gsh_lookup_idx), 64'd1);
        checkOutput("gsh_l1_predict", 64'(gsh_predict), 64'd1);
        applyGshareStimulus(1'b1, 32'h20, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
        checkOutput("gsh_l2_ghr", 64'(gsh_lookup_ghr), 64'h1);
        checkOutput("gsh_l2_idx", 64'(gsh_lookup_idx), 64'd9);
        checkOutput("gsh_l2_predict", 64'(gsh_predict), 64'd0);
        applyGshareStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
        checkOutput("gsh_l3_ghr", 64'(gsh_lookup_ghr), 64'h2);
        checkOutput("gsh_l3_idx", 64'(gsh_lookup_idx), 64'd1);
        checkOutput("gsh_l3_predict", 64'(gsh_predict), 64'd1);
        applyGshareStimulus(1'b1, 32'h0C, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
        checkOutput("gsh_ghr_0101", 64'(gsh_lookup_ghr), 64'h5);
        checkOutput("gsh_idx_3x5", 64'(gsh_lookup_idx), 64'd6);
        applyGshareStimulus(1'b0, 32'h00, 1'b1, 4'd0, 4'b0111, 1'b1, 1'b1);
        applyGshareStimulus(1'b1, 32'h0C, 1'b1, 4'd0, 4'b0101, 1'b1, 1'b1);
        checkOutput("gsh_ghr_1111", 64'(gsh_lookup_ghr), 64'hF);
        checkOutput("gsh_idx_3x15", 64'(gsh_lookup_idx), 64'd12);
        applyGshareStimulus(1'b1, 32'h04, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
        checkOutput("gsh_recover_prio", 64'(gsh_lookup_ghr), 64'hB);
        checkOutput("gsh_recover_idx", 64'(gsh_lookup_idx), 64'd10);
        applyGshareStimulus(1'b0, 32'h00, 1'b1, 4'd10, 4'b1111, 1'b1, 1'b0);
        applyGshareStimulus(1'b1, 32'h04, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
        checkOutput("gsh_nonmis_hold", 64'(gsh_lookup_ghr), 64'h6);
        checkOutput("gsh_branch_cnt", 64'(gsh_branch_cnt), 64'd4);
        checkOutput("gsh_mispredict_cnt", 64'(gsh_mispredict_cnt), 64'd2);
        applyGshareStimulus(1'b1, 32'h00, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);

        // Asynchronous reset mid-run, checked before the next rising edge
        @(negedge clk);
        bim_lookup_valid = 1'b1;
        bim_update_valid = 1'b0;
        gsh_update_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        for (int pc = 0; pc <= 32'h3C; pc += 4) begin
            bim_lookup_pc = 32'(pc);
            #1;
            checkOutput($sformatf("arst_predict_pc%0h", pc), 64'(bim_predict), 64'd0);
        end
        checkOutput("arst_bim_branch", 64'(bim_branch_cnt), 64'd0);
        checkOutput("arst_bim_mispredict", 64'(bim_mispredict_cnt), 64'd0);
        checkOutput("arst_gsh_branch", 64'(gsh_branch_cnt), 64'd0);
        checkOutput("arst_gsh_mispredict", 64'(gsh_mispredict_cnt), 64'd0);
        checkOutput("arst_gsh_ghr", 64'(gsh_lookup_ghr), 64'h0);
        checkOutput("arst_bim_ghr", 64'(bim_lookup_ghr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
Parametrised direction predictor that replaces the single-entry 2-bit predictor. It holds a table of saturating counters indexed by PC (bimodal) or PC XOR global history (gshare). Lookup happens in ID and the outcome is resolved in EX. The speculative global history register (GHR) recovers on mispredict, and saturating performance counters track branches and mispredicts.

Parameters:
PC_W, 32, PC width
ENTRIES, 16, counter-table depth; power of 2, at least 2; IDX_W = log2(ENTRIES)
CTR_BITS, 2, counter width, 1..4
CTR_INIT, 1, reset value of every counter (default is weakly not-taken)
MODE, 0, 0 = bimodal, 1 = gshare
GHR_BITS, 4, history length; must not exceed IDX_W when MODE=1
CNT_W, 32, width of each performance counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
lookup_valid_i  in  1  branch in ID, not stalled, not flushed
lookup_pc_i  in  PC_W  PC of the ID branch
predict_o  out  1  predicted taken (combinational)
lookup_idx_o  out  IDX_W  table index used; carried down the pipe
lookup_ghr_o  out  GHR_BITS  GHR value before this lookup; carried down the pipe
update_valid_i  in  1  branch resolved in EX
update_idx_i  in  IDX_W  index carried from lookup
update_ghr_i  in  GHR_BITS  GHR snapshot carried from lookup
update_taken_i  in  1  actual outcome
update_mispredict_i  in  1  prediction was wrong
clear_cnt_i  in  1  synchronous clear of the performance counters
branch_cnt_o  out  CNT_W  resolved branches
mispredict_cnt_o  out  CNT_W  mispredicts

Behaviour:
- Reset (rst_i=0, async, any time including mid-operation):
  - all counters = CTR_INIT; GHR = 0; both performance counts = 0.
  - predict_o = CTR_INIT[CTR_BITS-1].
- Index computation:
  - base = lookup_pc_i[IDX_W+1:2].
  - MODE=0: idx = base.
  - MODE=1: idx = base XOR zero-extended GHR.
- Lookup is combinational, zero latency: predict_o = MSB of ctr[idx]; lookup_idx_o = idx; lookup_ghr_o = GHR. These outputs are valid whenever lookup_valid_i=1 and don't-care otherwise.
- Counter update, at the clock edge when update_valid_i=1:
  - taken: ctr[update_idx_i] increments, saturating at 2^CTR_BITS-1.
  - not taken: decrements, saturating at 0.
  - No other entry changes.
- Same-index read and write in one cycle: predict_o shows the pre-update value. There is no bypass.
- GHR update at the clock edge, shifting left with the new bit in the LSB:
  - update_valid_i & update_mispredict_i: GHR <= {update_ghr_i[GHR_BITS-2:0], update_taken_i}. This has priority; a same-cycle lookup is wrong-path and is dropped.
  - otherwise, if lookup_valid_i: GHR <= {GHR[GHR_BITS-2:0], predict_o}.
  - otherwise GHR holds.
  - GHR is maintained in both modes but only affects the index when MODE=1.
- Performance counters:
  - clear_cnt_i has priority and zeroes both counts.
  - Otherwise branch_cnt increments on update_valid_i.
  - mispredict_cnt increments on update_valid_i & update_mispredict_i.
  - Both saturate at all-ones and never wrap.
- Mispredict redirect and flush are handled outside this block. It only learns from the update.
- Parameter violations cause an elaboration-time error.

Decomposition:
- Package bp_pkg:
  - BP_MODE_BIMODAL and BP_MODE_GSHARE constants.
  - sat_inc and sat_dec functions, parametrised by width.
  - CTR_INIT default.
- Sub-module bp_perf_counter (CNT_W, inc_i, clr_i, saturating), instantiated twice.
- The table, GHR and indexing logic stay in the top module.

Test Plan:
- Reset: ENTRIES=16, CTR_INIT=1. Pull rst_i low mid-run after training. Require predict_o=0 for PC 0x00..0x3C, both counts 0, lookup_ghr_o=0, all asynchronous, with no clock edge needed.
- Bimodal training, MODE=0:
  - 1 taken update at idx 3 → PC 0x0C predicts 1 (ctr=2).
  - 3 more taken → ctr stays 3.
  - 2 not-taken → ctr=1, predict 0.
  - 3 more not-taken → ctr stays 0.
  - PC 0x4C aliases to idx 3.
- Same-cycle read/write, MODE=0: lookup PC 0x0C while updating idx 3 taken from ctr=1 → predict_o=0 this cycle, 1 the next.
- gshare indexing, MODE=1, GHR_BITS=4: lookups predicted 1,0,1 → lookup_ghr_o=4'b0101. Lookup PC 0x0C → lookup_idx_o=3^5=6.
- Recovery priority: with GHR=4'b1111, assert update_valid_i + mispredict + taken with update_ghr_i=4'b0101 together with lookup_valid_i → next GHR=4'b1011. A non-mispredict update leaves GHR unchanged.
- Performance counters, CNT_W=4:
  - 20 updates, 5 of them mispredicted → branch_cnt=15 (saturated), mispredict_cnt=5.
  - clear_cnt_i together with an update → both 0 next cycle.
